line_fill_buffer: RTL and testbench
===================================

# line_fill_buffer

- Read-side counterpart of the cache write buffer: fetches whole cache lines from main memory into the cache.
- Accepts one miss request from the cache controller and issues a sequence of narrow read beats to main memory.
- Assembles the beats into a full line and presents the line to the cache for refill.
- Sits between the cache miss logic and the main-memory read port. One miss is outstanding at a time.

## Interface
Parameters (`ADDR_WIDTH` and `CACHELINE_WIDTH` come from `cache_define.v`):
- MEM_DATA_WIDTH, 32: width of one memory read beat in bits. Requirements: power of 2, and CACHELINE_WIDTH/MEM_DATA_WIDTH ≥ 2.
- BEATS, CACHELINE_WIDTH/MEM_DATA_WIDTH: beats per line (derived; must not be overridden).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_valid  in  1  cache requests a line fill.
- miss_ready  out  1  block can accept a miss (high only in IDLE).
- miss_addr  in  `ADDR_WIDTH`  byte address that missed ({tag, index, offset}).
- mem_rd_valid  out  1  read-beat address is valid.
- mem_rd_ready  in  1  memory accepts the beat address.
- mem_rd_addr  out  `ADDR_WIDTH`  byte address of the current beat.
- mem_rdata_valid  in  1  returned beat data is valid.
- mem_rdata  in  MEM_DATA_WIDTH  returned beat data.
- fill_valid  out  1  assembled line is available.
- fill_ready  in  1  cache consumes the line.
- fill_addr  out  `ADDR_WIDTH`  line-aligned address (offset bits zero).
- fill_data  out  `CACHELINE_WIDTH`  assembled line; beat k occupies bits [k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH].
- busy  out  1  high in any state other than IDLE.

## Operation
- State machine states: IDLE, REQ, RECV, FILL.
- IDLE:
  - miss_ready=1.
  - On miss_valid: latch the line address (miss_addr with offset zeroed) and the starting beat index, clear the beat counter, go to REQ.
- REQ:
  - mem_rd_valid=1, mem_rd_addr = line address + beat_idx*(MEM_DATA_WIDTH/8).
  - On mem_rd_ready: go to RECV.
  - mem_rd_addr must stay stable while stalled.
- RECV:
  - On mem_rdata_valid: write mem_rdata into line slot beat_idx.
  - beat_idx increments modulo BEATS (wraps from BEATS-1 to 0); the beat counter increments.
  - If this was beat number BEATS: go to FILL. Otherwise: go to REQ.
- FILL:
  - fill_valid=1; fill_addr and fill_data are held stable.
  - On fill_ready: go to IDLE.
- mem_rdata_valid outside RECV is ignored; no slot is written.
- miss_valid outside IDLE is ignored; miss_addr is not sampled.
- Counters are $clog2(BEATS) bits wide. Address arithmetic is modulo 2^`ADDR_WIDTH`.

## Timing
- Reset values:
  - state=IDLE, miss_ready=1.
  - mem_rd_valid=0, mem_rd_addr=0.
  - fill_valid=0, fill_addr=0, fill_data=0, busy=0.
- Reset asserted mid-operation aborts the fill: any partial line is discarded and no fill_valid is produced.
- Cycle-level sequence:
  - Miss is accepted at edge 0.
  - mem_rd_valid is high in cycle 1.
  - Best case (mem_rd_ready immediate, data one cycle later): each beat takes 2 cycles, and fill_valid rises in cycle 1+2*BEATS.
- fill_valid holds until fill_ready is seen. miss_ready rises the cycle after the fill handshake; there is no back-to-back miss acceptance in FILL.
- mem_rd_valid never deasserts without a handshake.

## Configuration
- Macro: `LINE_FILL_CRITICAL_WORD_FIRST_EN`.
- Defined: starting beat index = the beat containing miss_addr. Beats are fetched in wrap order (e.g. 2,3,0,1 for BEATS=4).
- Undefined: starting beat index = 0; beats are fetched 0..BEATS-1 and the miss_addr offset is ignored.
- fill_data layout is identical in both builds.

## Test plan
Bench build: `CACHELINE_WIDTH`=128, `ADDR_WIDTH`=32, MEM_DATA_WIDTH=32.
- Reset, then idle 5 cycles -> miss_ready=1, busy=0, mem_rd_valid=0, fill_valid=0, fill_data=0.
- Miss at 0x0000_1000, memory always ready with 1-cycle data return of 0xA0..0xA3 -> mem_rd_addr sequence 0x1000, 0x1004, 0x1008, 0x100C; fill_valid in cycle 9; fill_addr=0x1000; fill_data=0x000000A3_000000A2_000000A1_000000A0.
- Miss at 0x0000_2008 with the macro defined -> mem_rd_addr sequence 0x2008, 0x200C, 0x2000, 0x2004; fill_addr=0x2000; slots filled correctly. Without the macro -> sequence starts at 0x2000.
- mem_rd_ready held low for 3 cycles in REQ, and fill_ready held low for 4 cycles -> mem_rd_addr and fill_data stable throughout; miss_valid pulsed in FILL is not accepted.
- rst asserted during the beat-2 RECV, then a new miss at 0x3000 -> outputs return to reset values immediately; no fill for the aborted line; the next fill is 0x3000 with only new data.
- Spurious mem_rdata_valid=1 in IDLE and REQ -> no slot changes; fill_data contains only beats received in RECV.

Source files
------------

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: fetches one cache line from main memory as a series of
// narrow read beats and presents the assembled line to the cache for refill.
// Only one miss is outstanding at a time.
// Optional feature macro: LINE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> the fetch starts at the beat holding miss_addr and wraps.
//   undefined -> the fetch always starts at beat 0.
// The fill_data layout is the same in both builds.
module line_fill_buffer #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned CACHELINE_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_WIDTH-1:0]      miss_addr,
    output logic                       mem_rd_valid,
    input  logic                       mem_rd_ready,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic                       mem_rdata_valid,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_rdata,
    output logic                       fill_valid,
    input  logic                       fill_ready,
    output logic [ADDR_WIDTH-1:0]      fill_addr,
    output logic [CACHELINE_WIDTH-1:0] fill_data,
    output logic                       busy
);

    localparam int unsigned BEATS     = CACHELINE_WIDTH / MEM_DATA_WIDTH;
    localparam int unsigned BEAT_W    = $clog2(BEATS);
    localparam int unsigned BYTE_W    = $clog2(MEM_DATA_WIDTH / 8);
    localparam int unsigned LINE_MASK = (CACHELINE_WIDTH / 8) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        FILL = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        line_addr_q, line_addr_d;
    logic [ADDR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
    logic [BEAT_W-1:0]            beat_idx_q, beat_idx_d;
    logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [CACHELINE_WIDTH-1:0]   line_q, line_d;
    logic                         miss_ready_q, mem_rd_valid_q, fill_valid_q, busy_q;
    logic [ADDR_WIDTH-1:0]        aligned_addr_c;
    logic [BEAT_W-1:0]            start_idx_c;

    // Byte offset of a beat within the line.
    function automatic logic [ADDR_WIDTH-1:0] beat_offset(input logic [BEAT_W-1:0] idx);
        return ADDR_WIDTH'(idx) << BYTE_W;
    endfunction

    assign aligned_addr_c = miss_addr & ~ADDR_WIDTH'(LINE_MASK);

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_idx_c = miss_addr[BYTE_W +: BEAT_W];
`else
    assign start_idx_c = '0;
`endif

    // Next-state, beat sequencing and line assembly.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        rd_addr_d   = rd_addr_q;
        beat_idx_d  = beat_idx_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    line_addr_d = aligned_addr_c;
                    beat_idx_d  = start_idx_c;
                    beat_cnt_d  = '0;
                    line_d      = '0;
                    rd_addr_d   = aligned_addr_c + beat_offset(start_idx_c);
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_rd_ready) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (mem_rdata_valid) begin
                    for (int k = 0; k < int'(BEATS); k++) begin
                        if (beat_idx_q == BEAT_W'(k)) begin
                            line_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
                        end
                    end
                    beat_idx_d = beat_idx_q + BEAT_W'(1);
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    rd_addr_d  = line_addr_q + beat_offset(beat_idx_q + BEAT_W'(1));
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                        state_d = FILL;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            FILL: begin
                if (fill_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            line_addr_q    <= '0;
            rd_addr_q      <= '0;
            beat_idx_q     <= '0;
            beat_cnt_q     <= '0;
            line_q         <= '0;
            miss_ready_q   <= 1'b1;
            mem_rd_valid_q <= 1'b0;
            fill_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_addr_q    <= line_addr_d;
            rd_addr_q      <= rd_addr_d;
            beat_idx_q     <= beat_idx_d;
            beat_cnt_q     <= beat_cnt_d;
            line_q         <= line_d;
            miss_ready_q   <= (state_d == IDLE);
            mem_rd_valid_q <= (state_d == REQ);
            fill_valid_q   <= (state_d == FILL);
            busy_q         <= (state_d != IDLE);
        end
    end

    assign miss_ready   = miss_ready_q;
    assign mem_rd_valid = mem_rd_valid_q;
    assign mem_rd_addr  = rd_addr_q;
    assign fill_valid   = fill_valid_q;
    assign fill_addr    = line_addr_q;
    assign fill_data    = line_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: random beat data and stalls checked against a
// slot-array model of the line. Honours LINE_FILL_CRITICAL_WORD_FIRST_EN.
module tb_line_fill_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = LW / DW;

    logic          clk;
    logic          rst;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_addr;
    logic          mem_rd_valid;
    logic          mem_rd_ready;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rdata_valid;
    logic [DW-1:0] mem_rdata;
    logic          fill_valid;
    logic          fill_ready;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_line [NB];
    logic [AW-1:0] exp_addr   [NB];

    line_fill_buffer #(
        .ADDR_WIDTH     (AW),
        .CACHELINE_WIDTH(LW),
        .MEM_DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_addr      (miss_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_ready   (mem_rd_ready),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .fill_valid     (fill_valid),
        .fill_ready     (fill_ready),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] model_packed();
        logic [LW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NB); k++) r[k*DW +: DW] = model_line[k];
        return r;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_miss_ready"},   LW'(miss_ready),   LW'(1));
        chk({tag, "_busy"},         LW'(busy),         LW'(0));
        chk({tag, "_mem_rd_valid"}, LW'(mem_rd_valid), LW'(0));
        chk({tag, "_mem_rd_addr"},  LW'(mem_rd_addr),  LW'(0));
        chk({tag, "_fill_valid"},   LW'(fill_valid),   LW'(0));
        chk({tag, "_fill_addr"},    LW'(fill_addr),    LW'(0));
        chk({tag, "_fill_data"},    fill_data,         LW'(0));
    endtask

    // One miss end to end. rd_stall delays the first address handshake,
    // fill_stall delays fill_ready (with a miss pulse inside), spurious drives
    // junk data outside RECV, abort_beat >= 0 resets before that beat lands.
    task automatic run_miss(input logic [AW-1:0] addr, input int rd_stall, input int fill_stall,
                            input bit spurious, input int abort_beat, input bit fixed_data);
        int            start;
        int            beat;
        int            stall_left;
        int            slot;
        bit            pending;
        bit            done;
        logic [AW-1:0] line;
        logic [DW-1:0] d;

        line = addr & ~AW'(LW / 8 - 1);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        start = int'((addr % (LW / 8)) / (DW / 8));
`else
        start = 0;
`endif
        for (int k = 0; k < int'(NB); k++) begin
            exp_addr[k]   = line + AW'(((start + k) % NB) * (DW / 8));
            model_line[k] = '0;
        end

        @(negedge clk);
        chk("miss_ready_idle", LW'(miss_ready), LW'(1));
        miss_valid      = 1'b1;
        miss_addr       = addr;
        mem_rdata_valid = spurious;
        mem_rdata       = $urandom;
        @(negedge clk);
        miss_valid      = 1'b0;
        miss_addr       = $urandom;
        mem_rdata_valid = spurious;
        mem_rdata       = $urandom;
        chk("busy_cycle1",         LW'(busy),         LW'(1));
        chk("miss_ready_cycle1",   LW'(miss_ready),   LW'(0));
        chk("mem_rd_valid_cycle1", LW'(mem_rd_valid), LW'(1));

        beat       = 0;
        pending    = 1'b0;
        done       = 1'b0;
        stall_left = rd_stall;
        for (int cyc = 1; cyc < 200 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (pending) begin
                mem_rd_ready = 1'b0;
                if (beat == abort_beat) begin
                    mem_rdata_valid = 1'b0;
                    rst = 1'b1;
                    #1;
                    chk_reset_values("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("abort_no_fill", LW'(fill_valid), LW'(0));
                        chk("abort_idle",    LW'(busy),       LW'(0));
                    end
                    return;
                end
                chk("recv_rd_valid_low", LW'(mem_rd_valid), LW'(0));
                slot            = (start + beat) % NB;
                d               = fixed_data ? DW'(32'hA0 + slot) : DW'($urandom);
                model_line[slot] = d;
                mem_rdata_valid = 1'b1;
                mem_rdata       = d;
                beat++;
                pending = 1'b0;
            end else begin
                mem_rdata_valid = spurious;
                mem_rdata       = $urandom;
                if (fill_valid) begin
                    if (rd_stall == 0) chk("fill_cycle", LW'(cyc), LW'(1 + 2 * NB));
                    chk("fill_beats", LW'(beat), LW'(NB));
                    chk("fill_addr", LW'(fill_addr), LW'(line));
                    chk("fill_data", fill_data, model_packed());
                    for (int s = 0; s < fill_stall; s++) begin
                        fill_ready = 1'b0;
                        miss_valid = (s == 1);
                        miss_addr  = 32'h0000_7000;
                        @(negedge clk);
                        mem_rdata_valid = spurious;
                        mem_rdata       = $urandom;
                        chk("fill_hold_valid", LW'(fill_valid), LW'(1));
                        chk("fill_hold_addr",  LW'(fill_addr),  LW'(line));
                        chk("fill_hold_data",  fill_data,       model_packed());
                    end
                    miss_valid = 1'b0;
                    fill_ready = 1'b1;
                    @(negedge clk);
                    fill_ready      = 1'b0;
                    mem_rdata_valid = 1'b0;
                    chk("post_fill_miss_ready", LW'(miss_ready),   LW'(1));
                    chk("post_fill_busy",       LW'(busy),         LW'(0));
                    chk("post_fill_valid",      LW'(fill_valid),   LW'(0));
                    chk("post_fill_rd_valid",   LW'(mem_rd_valid), LW'(0));
                    done = 1'b1;
                end else if (mem_rd_valid) begin
                    if (beat < int'(NB)) chk("mem_rd_addr", LW'(mem_rd_addr), LW'(exp_addr[beat]));
                    else chk("extra_beat", LW'(beat), LW'(NB - 1));
                    if (stall_left > 0) begin
                        stall_left--;
                        mem_rd_ready = 1'b0;
                    end else begin
                        mem_rd_ready = 1'b1;
                        pending      = 1'b1;
                    end
                end else begin
                    mem_rd_ready = 1'b0;
                    chk("req_expected", LW'(mem_rd_valid), LW'(1));
                end
            end
        end
        chk("fill_timeout", LW'(done), LW'(1));
    endtask

    initial begin
        rst             = 1'b1;
        miss_valid      = 1'b0;
        miss_addr       = '0;
        mem_rd_ready    = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        fill_ready      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_values("reset");

        run_miss(32'h0000_1000, 0, 0, 1'b0, -1, 1'b1);
        chk("fixed_line", fill_data, 128'h000000A3_000000A2_000000A1_000000A0);

        run_miss(32'h0000_2008, 0, 0, 1'b0, -1, 1'b0);
        run_miss(32'h0000_4004, 3, 4, 1'b0, -1, 1'b0);
        run_miss(32'h0000_5000, 0, 0, 1'b0, 2, 1'b0);
        run_miss(32'h0000_3000, 0, 0, 1'b0, -1, 1'b0);
        run_miss(32'h0000_600C, 1, 2, 1'b1, -1, 1'b0);
        run_miss(32'hFFFF_FFF4, 0, 1, 1'b0, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_miss(AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
